// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann definitions: default lattice geometry, moment type, reader FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lbm_pkg;

    localparam int LBM_DIM_X      = 16;
    localparam int LBM_DIM_Y      = 16;
    localparam int LBM_DATA_WIDTH = 32;

    typedef logic signed [LBM_DATA_WIDTH-1:0] moment_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/lattice_addr_counter.sv
// Raster-order lattice cell counter: tracks (x, y) and the linear RAM address together.
// Latency: one cycle from advance to the next cell, clear takes effect on the next edge.
// Backpressure: holds its position whenever advance is low.
//
// Ports: Clk/Reset_n clock and async active-low reset; clear returns to cell 0;
// advance steps to the next cell (wrapping after the last); x, y, addr current cell;
// is_last high when the current cell is DEPTH-1.
module lattice_addr_counter #(
    parameter int DIM_X         = 16,
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = 8,
    parameter int X_W           = 4,
    parameter int Y_W           = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     clear,
    input  logic                     advance,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     is_last
);

    localparam logic [X_W-1:0]           X_MAX    = X_W'(DIM_X - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_WIDTH'(DEPTH - 1);

    logic [X_W-1:0]           r_x;
    logic [Y_W-1:0]           r_y;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     w_is_last;

    // Raster order means y*DIM_X + x is just a running index, so the
    // address steps by one alongside x/y instead of being multiplied out.
    assign w_is_last = (r_addr == ADDR_MAX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (advance) begin
            if (w_is_last) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= '0;
            end else if (r_x == X_MAX) begin
                r_x    <= '0;
                r_y    <= r_y + 1'b1;
                r_addr <= r_addr + 1'b1;
            end else begin
                r_x    <= r_x + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    assign addr    = r_addr;
    assign is_last = w_is_last;

endmodule

// File: rtl/moment_ram_reader.sv
// Sweeps the moment RAM in raster order and streams each cell as a tagged valid/ready beat.
// Latency: first beat valid two edges after start is sampled, then one beat per cycle.
// Backpressure: out_ready low freezes the output beat and the cell counter; nothing is dropped.
//
// Ports: Clk/Reset_n clock and async active-low reset; start sweep request (IDLE only);
// busy sweep in progress (through the done cycle); done one-cycle completion pulse;
// ram_address/ram_data combinational read port; out_valid/out_ready/out_data/out_x/
// out_y/out_last output stream.
// Optional: MOMENT_RAM_READER_SUM_EN adds a signed running sum of all handshaken beats.
module moment_ram_reader
    import lbm_pkg::*;
#(
    parameter int DIM_X         = LBM_DIM_X,
    parameter int DIM_Y         = LBM_DIM_Y,
    parameter int DEPTH         = DIM_X * DIM_Y,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = LBM_DATA_WIDTH
) (
    input  logic                                  Clk,
    input  logic                                  Reset_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [ADDRESS_WIDTH-1:0]              ram_address,
    input  logic signed [DATA_WIDTH-1:0]          ram_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(DIM_X)-1:0]              out_x,
    output logic [$clog2(DIM_Y)-1:0]              out_y,
    output logic                                  out_last
`ifdef MOMENT_RAM_READER_SUM_EN
    ,
    output logic signed [DATA_WIDTH+ADDRESS_WIDTH-1:0] sum
`endif
);

    localparam int X_W = $clog2(DIM_X);
    localparam int Y_W = $clog2(DIM_Y);

    reader_state_t            r_state;
    reader_state_t            w_state_nxt;
    logic                     r_done;
    logic                     w_accept;
    logic                     w_free;
    logic                     w_load;
    logic                     w_hs;
    logic [X_W-1:0]           w_x;
    logic [Y_W-1:0]           w_y;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic                     w_is_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_free   = !out_valid || out_ready;
    assign w_load   = (r_state == SCAN) && w_free;
    assign w_hs     = out_valid && out_ready;

    lattice_addr_counter #(
        .DIM_X         (DIM_X),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .X_W           (X_W),
        .Y_W           (Y_W)
    ) u_counter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (w_accept),
        .advance (w_load),
        .x       (w_x),
        .y       (w_y),
        .addr    (w_addr),
        .is_last (w_is_last)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state. DRAIN is held through the done cycle so busy covers it
    // and a start arriving alongside done is not mistaken for a new request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN;
            SCAN:    if (w_load && w_is_last) w_state_nxt = DRAIN;
            DRAIN:   if (r_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state. The RAM only sees a live address while
    // scanning; its data is sampled in that same cycle.
    always_comb begin
        busy        = (r_state != IDLE);
        ram_address = '0;
        if (r_state == SCAN) begin
            ram_address = w_addr;
        end
    end

    // Output beat register and done pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                out_valid <= 1'b1;
                out_data  <= ram_data;
                out_x     <= w_x;
                out_y     <= w_y;
                out_last  <= w_is_last;
            end else if ((r_state == DRAIN) && w_hs) begin
                out_valid <= 1'b0;
                r_done    <= 1'b1;
            end
        end
    end

    assign done = r_done;

`ifdef MOMENT_RAM_READER_SUM_EN
    logic signed [DATA_WIDTH+ADDRESS_WIDTH-1:0] r_sum;

    // Wide enough for DEPTH full-scale moments, so it never wraps.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_hs) begin
            r_sum <= r_sum + {{ADDRESS_WIDTH{out_data[DATA_WIDTH-1]}}, out_data};
        end
    end

    assign sum = r_sum;
`endif

endmodule

// File: tb/tb_moment_ram_reader.sv
module tb_moment_ram_reader;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16x16 instance
    logic               start, out_ready, busy, done, out_valid, out_last;
    logic [7:0]         ram_address;
    logic signed [31:0] ram_data, out_data;
    logic [3:0]         out_x, out_y;
    logic signed [31:0] mem [0:255];
    assign ram_data = mem[ram_address];

    // 4x3 instance
    logic               s_start, s_ready, s_busy, s_done, s_valid, s_last;
    logic [3:0]         s_addr;
    logic signed [31:0] s_ram_data, s_out_data;
    logic [1:0]         s_x, s_y;
    logic signed [31:0] mem2 [0:15];
    assign s_ram_data = mem2[s_addr];

`ifdef MOMENT_RAM_READER_SUM_EN
    logic signed [39:0] sum;
    logic signed [35:0] s_sum;
`endif

    moment_ram_reader u_dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_last    (out_last)
`ifdef MOMENT_RAM_READER_SUM_EN
        ,
        .sum         (sum)
`endif
    );

    moment_ram_reader #(.DIM_X(4), .DIM_Y(3)) u_small (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .start       (s_start),
        .busy        (s_busy),
        .done        (s_done),
        .ram_address (s_addr),
        .ram_data    (s_ram_data),
        .out_valid   (s_valid),
        .out_ready   (s_ready),
        .out_data    (s_out_data),
        .out_x       (s_x),
        .out_y       (s_y),
        .out_last    (s_last)
`ifdef MOMENT_RAM_READER_SUM_EN
        ,
        .sum         (s_sum)
`endif
    );

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_valid: valid=%b last=%b, expected 0 0", out_valid, out_last); end
        checks++; if (out_data !== 32'sd0) begin errors++; $display("FAIL reset_data: got %0d, expected 0", out_data); end
        checks++; if (out_x !== 4'd0 || out_y !== 4'd0) begin errors++; $display("FAIL reset_xy: got (%0d,%0d), expected (0,0)", out_x, out_y); end
        checks++; if (ram_address !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", ram_address); end
`ifdef MOMENT_RAM_READER_SUM_EN
        checks++; if (sum !== 40'sd0) begin errors++; $display("FAIL reset_sum: got %0d, expected 0", sum); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", busy, out_valid); end
    endtask

    task automatic test_full_sweep;
        int bad_valid, bad_data, bad_xy, bad_last, ii;
        logic signed [31:0] exp_d;
        logic [3:0] ex, ey;
        bad_valid = 0; bad_data = 0; bad_xy = 0; bad_last = 0;
        for (int i = 0; i < 256; i++) mem[i] = i - 128;
        @(negedge clk); out_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL start_latency: busy=%b valid=%b, expected 1 0", busy, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== -32'sd128) begin errors++; $display("FAIL first_beat: valid=%b data=%0d, expected 1 -128", out_valid, out_data); end
        for (int i = 0; i < 256; i++) begin
            ii = i; exp_d = ii - 128; ex = ii[3:0]; ey = ii[7:4];
            if (out_valid !== 1'b1) bad_valid++;
            if (out_data !== exp_d) bad_data++;
            if (out_x !== ex || out_y !== ey) bad_xy++;
            if (out_last !== (i == 255)) bad_last++;
            @(negedge clk);
        end
        checks++; if (bad_valid !== 0) begin errors++; $display("FAIL sweep_bubbles: %0d cycles without valid, expected 0", bad_valid); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL sweep_data: %0d wrong beats, expected 0", bad_data); end
        checks++; if (bad_xy !== 0) begin errors++; $display("FAIL sweep_xy: %0d wrong coordinates, expected 0", bad_xy); end
        checks++; if (bad_last !== 0) begin errors++; $display("FAIL sweep_last: %0d wrong last flags, expected 0", bad_last); end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL done_pulse: done=%b valid=%b busy=%b, expected 1 0 1", done, out_valid, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_end: done=%b busy=%b, expected 0 0", done, busy); end
    endtask

    task automatic test_backpressure;
        int idx, cyc, stalls, bad_order, bad_stable;
        bit stalled, seen_done, r;
        bit pat [0:3];
        logic signed [31:0] sv_d, exp_d;
        logic [3:0] sv_x, sv_y, ex, ey;
        logic sv_l;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        idx = 0; cyc = 0; stalls = 0; bad_order = 0; bad_stable = 0;
        stalled = 1'b0; seen_done = 1'b0;
        sv_d = '0; sv_x = '0; sv_y = '0; sv_l = 1'b0;
        @(negedge clk); out_ready = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 3000 && !seen_done) begin
            if (stalled) begin
                if (out_valid !== 1'b1 || out_data !== sv_d || out_x !== sv_x || out_y !== sv_y || out_last !== sv_l)
                    bad_stable++;
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else begin
                r = (cyc < 32) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
                out_ready = r;
                stalled = 1'b0;
                if (out_valid === 1'b1) begin
                    if (r) begin
                        exp_d = idx - 128; ex = idx[3:0]; ey = idx[7:4];
                        if (out_data !== exp_d || out_x !== ex || out_y !== ey || out_last !== (idx == 255))
                            bad_order++;
                        idx++;
                    end else begin
                        sv_d = out_data; sv_x = out_x; sv_y = out_y; sv_l = out_last;
                        stalled = 1'b1;
                        stalls++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL bp_timeout: done seen=%b, expected 1", seen_done); end
        checks++; if (idx !== 256) begin errors++; $display("FAIL bp_count: %0d beats, expected 256", idx); end
        checks++; if (bad_order !== 0) begin errors++; $display("FAIL bp_order: %0d wrong beats, expected 0", bad_order); end
        checks++; if (bad_stable !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls, expected 0", bad_stable); end
        checks++; if (stalls < 1) begin errors++; $display("FAIL bp_stalls: %0d stalls seen, expected >0", stalls); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b, expected 0", busy); end
    endtask

    task automatic test_start_held;
        int cyc, beats, bad;
        bit seen;
        logic signed [31:0] exp_d;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        cyc = 0; beats = 0; bad = 0; seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk); cyc++;
            if (done === 1'b1) seen = 1'b1;
            else if (out_valid === 1'b1) begin
                exp_d = beats - 128;
                if (out_data !== exp_d) bad++;
                beats++;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL held_timeout: done seen=%b, expected 1", seen); end
        checks++; if (beats !== 256 || bad !== 0) begin errors++; $display("FAIL held_single_sweep: beats=%0d bad=%0d, expected 256 0", beats, bad); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_busy_done: busy=%b, expected 1", busy); end
        @(negedge clk); cyc++;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL held_ignore_on_done: busy=%b done=%b valid=%b, expected 0 0 0", busy, done, out_valid); end
        @(negedge clk); cyc++;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL held_restart: busy=%b valid=%b, expected 1 0", busy, out_valid); end
        @(negedge clk); cyc++;
        checks++; if (out_valid !== 1'b1 || out_data !== -32'sd128 || out_x !== 4'd0 || out_y !== 4'd0) begin errors++; $display("FAIL held_second_first: valid=%b data=%0d x=%0d y=%0d, expected 1 -128 0 0", out_valid, out_data, out_x, out_y); end
        while (cyc < 300) begin @(negedge clk); cyc++; end
        start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk); cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL held_second_done: done seen=%b, expected 1", seen); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int beats, cyc;
        bit seen;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 38 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (out_valid === 1'b1) beats++;
        end
        checks++; if (beats !== 38) begin errors++; $display("FAIL mid_reach: %0d beats, expected 38", beats); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: valid=%b busy=%b done=%b, expected 0 0 0", out_valid, busy, done); end
        checks++; if (out_data !== 32'sd0 || out_x !== 4'd0 || out_y !== 4'd0 || ram_address !== 8'd0) begin errors++; $display("FAIL mid_reset_data: data=%0d x=%0d y=%0d addr=%0d, expected all 0", out_data, out_x, out_y, ram_address); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== -32'sd128 || out_x !== 4'd0 || out_y !== 4'd0) begin errors++; $display("FAIL mid_restart: valid=%b data=%0d x=%0d y=%0d, expected 1 -128 0 0", out_valid, out_data, out_x, out_y); end
        cyc = 0; seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk); cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_done: done seen=%b, expected 1", seen); end
        @(negedge clk);
    endtask

    task automatic test_small_dim;
        int bad, cyc, ii;
        logic signed [31:0] exp_d;
        logic [1:0] ex, ey;
        bad = 0; cyc = 0;
        for (int i = 0; i < 16; i++) mem2[i] = (i < 12) ? i * 3 + 5 : 0;
        s_ready = 1'b1;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        while (s_valid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL small_first: valid=%b, expected 1", s_valid); end
        for (int i = 0; i < 12; i++) begin
            ii = i; exp_d = ii * 3 + 5; ex = 2'(ii % 4); ey = 2'(ii / 4);
            if (s_valid !== 1'b1 || s_out_data !== exp_d || s_x !== ex || s_y !== ey || s_last !== (i == 11)) bad++;
            if (i == 11) begin
                checks++; if (s_x !== 2'd3 || s_y !== 2'd2 || s_last !== 1'b1) begin errors++; $display("FAIL small_last: x=%0d y=%0d last=%b, expected 3 2 1", s_x, s_y, s_last); end
            end
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL small_beats: %0d wrong beats, expected 0", bad); end
        checks++; if (s_done !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL small_done: done=%b valid=%b, expected 1 0", s_done, s_valid); end
`ifdef MOMENT_RAM_READER_SUM_EN
        checks++; if (s_sum !== 36'sd258) begin errors++; $display("FAIL small_sum: got %0d, expected 258", s_sum); end
`endif
        @(negedge clk);
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL small_idle: busy=%b, expected 0", s_busy); end
    endtask

`ifdef MOMENT_RAM_READER_SUM_EN
    task automatic test_sum;
        int cyc;
        bit seen;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = -32'sd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk); cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1 || sum !== -40'sd256) begin errors++; $display("FAIL sum_neg: done=%b sum=%0d, expected 1 -256", seen, sum); end
        repeat (3) @(negedge clk);
        checks++; if (sum !== -40'sd256) begin errors++; $display("FAIL sum_hold: got %0d, expected -256", sum); end
        for (int i = 0; i < 256; i++) mem[i] = 32'sh7fffffff;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (sum !== 40'sd0) begin errors++; $display("FAIL sum_clear: got %0d, expected 0", sum); end
        cyc = 0; seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk); cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1 || sum !== 40'sd549755813632) begin errors++; $display("FAIL sum_max: done=%b sum=%0d, expected 1 549755813632", seen, sum); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        for (int i = 0; i < 16; i++) mem2[i] = 0;
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_start_held();
        test_reset_mid();
        test_small_dim();
`ifdef MOMENT_RAM_READER_SUM_EN
        test_sum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moment_ram_reader.md
# moment_ram_reader

Initiator-side streamer for the lattice moment RAM: on a start pulse it sweeps every lattice cell in raster order, drives the RAM address, and captures the combinationally-read moment. Each moment leaves on a valid/ready stream tagged with its (x, y) coordinates and a last-cell flag. It sits between the moment RAM and downstream consumers such as the display/readout path and the collision stage, and never writes the RAM.

## Interface
- DIM_X, 16, lattice width in cells
- DIM_Y, 16, lattice height in cells
- DEPTH, DIM_X*DIM_Y, number of RAM entries swept
- ADDRESS_WIDTH, $clog2(DEPTH), RAM address width
- DATA_WIDTH, 32, signed moment width

Ports:
- Clk  in  1  single clock, all state on posedge
- Reset_n  in  1  reset, asynchronous, active-low
- start  in  1  sweep request, sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last beat handshakes
- ram_address  out  ADDRESS_WIDTH  address to moment RAM
- ram_data  in  DATA_WIDTH signed  combinational RAM read data for ram_address
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_WIDTH signed  moment value
- out_x  out  $clog2(DIM_X)  cell column
- out_y  out  $clog2(DIM_Y)  cell row
- out_last  out  1  beat is cell DEPTH-1

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: ram_address=0, busy=0; start=1 -> SCAN, address counter cleared.
- SCAN: output register "free" when out_valid=0 or out_ready=1. When free, load out_data<=ram_data, out_x/out_y/out_last from counter, out_valid<=1, advance counter. Loading cell DEPTH-1 -> DRAIN.
- DRAIN: no loads; if out_valid and out_ready, out_valid<=0, done<=1, -> IDLE.
- If out_valid=1 and out_ready=0, out_data/out_x/out_y/out_last hold stable and the counter does not advance.
- Address mapping: ram_address = y*DIM_X + x; x increments fastest, wraps DIM_X-1 -> 0 with y+1. out_last=1 only for x=DIM_X-1, y=DIM_Y-1.
- start while busy: ignored, no restart and no queuing.
- start in the same cycle as done: ignored, because the FSM is not yet in IDLE. A new start is accepted from the cycle after done.
- ram_data is trusted only in the cycle its address is driven. The block never writes the RAM.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_x=0, out_y=0, out_last=0, ram_address=0, state=IDLE.
- start=1 sampled at edge E: busy=1 after E; out_valid=1 with cell 0 after E+1.
- With out_ready held high: one beat per cycle, DEPTH consecutive beats, no bubbles.
- Last beat handshakes at edge L: out_valid=0 and done=1 after L; done=0 and busy=0 after L+1. busy therefore stays high through the done cycle.
- Reset_n low at any time, including mid-sweep or under backpressure: all outputs go to their reset values immediately. The next sweep restarts at cell 0.

## Configuration
- MOMENT_RAM_READER_SUM_EN defined: adds output sum (DATA_WIDTH+ADDRESS_WIDTH bits, signed).
  - sum is cleared when start is accepted.
  - It accumulates each out_data on handshake, with sign extension and no saturation.
  - It holds its value after done until the next accepted start; reset value 0.
  - Used as the mass-conservation check.
- Not defined: no sum port and no accumulator logic; all other behaviour is identical.

## Structure
- Shared package lbm_pkg:
  - default DIM_X, DIM_Y and DATA_WIDTH constants;
  - typedef moment_t (signed DATA_WIDTH);
  - the reader state enum typedef (IDLE, SCAN, DRAIN).
- One sub-module: lattice_addr_counter.
  - Inputs: clear, advance.
  - Outputs: x, y, addr and is_last.
  - addr is maintained incrementally, with no multiplier.
- The FSM and output register stay in the top module.

## Test plan
- Preload mem[i]=i-128, start pulse, out_ready=1 -> 256 beats with out_data=-128..127 in order; out_x/out_y=(i%16, i/16); out_last only on beat 255; done one cycle after beat 255.
- out_ready toggled 1,0,0,1 pseudo-randomly -> no beat dropped or duplicated; out_data/out_x/out_y stable while stalled; beat count 256.
- start held high for 300 cycles -> exactly one sweep, then a second sweep begins the cycle after done.
- Reset_n pulsed low after beat 37 -> out_valid=0 and busy=0 immediately; next start streams from cell 0.
- DIM_X=4, DIM_Y=3 instance -> 12 beats; x wraps at 3; out_last on (3,2).
- With MOMENT_RAM_READER_SUM_EN, mem[i]=-1 for all i -> sum=-256 at done. A second run with mem[i]=2^31-1 gives sum=256*(2^31-1) with no overflow.
